// File: rtl/us_pkg.sv
// rtl/us_pkg.sv - shared state encoding and widths for the ultrasonic range filter
// Purpose: one place for the FSM states and the sample/sum/window sizes so the
//          scheduler and the averager agree on them.
// Ports:   none (package).
package us_pkg;

    localparam int DIST_W    = 9;   // distance sample width, cm
    localparam int SUM_W     = 11;  // holds 4 * 511 without overflow
    localparam int WIN_DEPTH = 4;   // moving-average window length
    localparam int FILL_W    = 3;   // counts 0..WIN_DEPTH

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT,
        ACCUM,
        GAP
    } us_state_t;

endpackage

// File: rtl/us_avg4.sv
// rtl/us_avg4.sv - 4-entry moving average with running sum and fill count
// Purpose: keeps the last WIN_DEPTH samples, a running sum, and publishes
//          sum/4 once the window is full.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   push       one-cycle strobe: shift sample into the window
//   sample     new distance sample, cm
//   avg        truncated average of the window, cm
//   avg_valid  one-cycle pulse the cycle after a push that leaves the window full
module us_avg4
    import us_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DIST_W-1:0] sample,
    output logic [DIST_W-1:0] avg,
    output logic              avg_valid
);

    logic [DIST_W-1:0] win [WIN_DEPTH];
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;

    // Slots start at zero, so subtracting the oldest entry is harmless while filling.
    always_comb begin
        sum_next  = sum + SUM_W'(sample) - SUM_W'(win[WIN_DEPTH-1]);
        fill_next = (fill == FILL_W'(WIN_DEPTH)) ? fill : fill + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win[i] <= '0;
            end
            sum       <= '0;
            fill      <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (push) begin
                win[0] <= sample;
                for (int i = 1; i < WIN_DEPTH; i++) begin
                    win[i] <= win[i-1];
                end
                sum  <= sum_next;
                fill <= fill_next;
                if (fill_next == FILL_W'(WIN_DEPTH)) begin
                    avg       <= sum_next[SUM_W-1:2];
                    avg_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/us_range_filter.sv
// rtl/us_range_filter.sv - measurement scheduler, smoother and fault monitor for the ranging core
// Purpose: pulses us_init periodically, collects each distance sample, smooths it
//          over 4 samples, drives a hysteretic obstacle flag and flags a dead sensor.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   enable        1 = keep measuring; a drop takes effect at the end of the gap
//   us_done       done level from the ranging core (foreign clock domain)
//   us_distance   distance in cm, stable while us_done is high
//   us_init       measurement request to the core
//   dist_avg      moving average of the last 4 samples, cm
//   dist_valid    one-cycle pulse when dist_avg updates
//   obstacle      set below NEAR_CM, cleared above FAR_CM
//   sensor_fault  sticky: MAX_MISS consecutive timeouts seen
//   miss_cnt      saturating count of consecutive misses
module us_range_filter
    import us_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int PERIOD_CYC    = 6_000_000,
    parameter int INIT_HOLD_CYC = 200,
    parameter int TIMEOUT_CYC   = 3_000_000,
    parameter int NEAR_CM       = 20,
    parameter int FAR_CM        = 25,
    parameter int MAX_MISS      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              us_done,
    input  logic [DIST_W-1:0] us_distance,
    output logic              us_init,
    output logic [DIST_W-1:0] dist_avg,
    output logic              dist_valid,
    output logic              obstacle,
    output logic              sensor_fault,
    output logic [1:0]        miss_cnt
);

    if (FAR_CM < NEAR_CM || CLK_HZ <= 0) begin : g_cfg_check
        $error("us_range_filter: FAR_CM must be >= NEAR_CM and CLK_HZ positive");
    end

    localparam int CNT_MAX_A = (PERIOD_CYC > TIMEOUT_CYC) ? PERIOD_CYC : TIMEOUT_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > INIT_HOLD_CYC) ? CNT_MAX_A : INIT_HOLD_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    us_state_t         state;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [DIST_W-1:0] sample;
    logic [1:0]        miss_next;
    logic              sync1;
    logic              sync2;
    logic              sync_prev;
    logic              done_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= us_done;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign done_rise = sync2 & ~sync_prev;
    assign miss_next = (miss_cnt == 2'd3) ? 2'd3 : miss_cnt + 2'd1;

    // Period and timeout are both measured from TRIG entry, so one counter serves
    // both. It saturates rather than wraps so an oversized timeout cannot alias
    // into an early period end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            us_init      <= 1'b0;
            sample       <= '0;
            miss_cnt     <= 2'd0;
            sensor_fault <= 1'b0;
        end else begin
            if (cyc_cnt != CNT_W'(CNT_MAX)) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        cyc_cnt <= '0;
                        us_init <= 1'b1;
                        state   <= TRIG;
                    end
                end
                TRIG: begin
                    if (cyc_cnt >= CNT_W'(INIT_HOLD_CYC - 1)) begin
                        us_init <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Any rise seen while init was high is ignored: the core
                    // clears done on init, so only rises observed here are fresh.
                    if (done_rise) begin
                        sample <= us_distance;
                        state  <= ACCUM;
                    end else if (cyc_cnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
                        miss_cnt <= miss_next;
                        if (int'(miss_next) >= MAX_MISS) begin
                            sensor_fault <= 1'b1;
                        end
                        state <= GAP;
                    end
                end
                ACCUM: begin
                    miss_cnt <= 2'd0;
                    state    <= GAP;
                end
                GAP: begin
                    if (cyc_cnt >= CNT_W'(PERIOD_CYC - 1)) begin
                        if (enable) begin
                            cyc_cnt <= '0;
                            us_init <= 1'b1;
                            state   <= TRIG;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    us_avg4 u_avg4 (
        .clk       (clk),
        .rst       (rst),
        .push      (state == ACCUM),
        .sample    (sample),
        .avg       (dist_avg),
        .avg_valid (dist_valid)
    );

    // Between the two thresholds the previous decision stands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obstacle <= 1'b0;
        end else if (dist_valid) begin
            if (dist_avg < DIST_W'(NEAR_CM)) begin
                obstacle <= 1'b1;
            end else if (dist_avg > DIST_W'(FAR_CM)) begin
                obstacle <= 1'b0;
            end
        end
    end

endmodule
